// File: rtl/wb_arb_pkg.sv
// Shared types, bus widths and default tuning values for the two-master
// Wishbone arbiter.
package wb_arb_pkg;

    localparam int unsigned AddrWidth = 30;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned SelWidth  = 4;

    localparam int unsigned DefaultTimeoutCycles  = 1000;
    localparam int unsigned DefaultMaxOutstanding = 15;

    typedef enum logic [1:0] {
        StIdle,
        StOwnA,
        StOwnB,
        StAbort
    } arb_state_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Pipelined Wishbone link; the master modport drives the request, the slave
// modport drives the response.
interface wb_arbiter_if;
    import wb_arb_pkg::*;

    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [SelWidth-1:0]  sel;
    logic                 stall;
    logic                 ack;
    logic                 err;
    logic [DataWidth-1:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  stall, ack, err, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output stall, ack, err, rdata
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// Watchdog for a stuck slave: counts enabled cycles and flags the cycle in
// which the count reaches TIMEOUT_CYCLES.
module wb_timeout_counter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntWidth-1:0] count_q, count_d;

    // The current enabled cycle is the TIMEOUT_CYCLES-th one
    assign expired = enable && (count_q == CntWidth'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master pipelined Wishbone arbiter: round-robin grant, outstanding-request
// limit and a timeout that aborts a transaction the slave never answers.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = DefaultTimeoutCycles,
    parameter int unsigned MAX_OUTSTANDING = DefaultMaxOutstanding
) (
    input logic          i_clk,
    input logic          i_reset,
    wb_arbiter_if.slave  a_bus,
    wb_arbiter_if.slave  b_bus,
    wb_arbiter_if.master wb_bus
);

    localparam int unsigned OutWidth = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e          state_q, state_d;
    logic                last_b_q, last_b_d;
    logic [OutWidth-1:0] out_q, out_d;

    logic own_a, own_b, own;
    logic owner_cyc, owner_stb, other_cyc, abort_cyc;
    logic has_out, full, release_grant, expire, live;
    logic fwd_ack, fwd_err, stb_out, accept;
    logic tmo_clear, tmo_enable, tmo_expired;

    // Reset masks ownership so every output falls to its idle value at once
    assign own_a = !i_reset && (state_q == StOwnA);
    assign own_b = !i_reset && (state_q == StOwnB);
    assign own   = own_a | own_b;

    assign owner_cyc = own_a ? a_bus.cyc : (own_b & b_bus.cyc);
    assign owner_stb = own_a ? a_bus.stb : b_bus.stb;
    assign other_cyc = own_a ? b_bus.cyc : a_bus.cyc;
    assign abort_cyc = last_b_q ? b_bus.cyc : a_bus.cyc;

    assign has_out       = (out_q != '0);
    assign full          = (out_q == OutWidth'(MAX_OUTSTANDING));
    assign release_grant = own & ~owner_cyc;
    assign expire        = owner_cyc & tmo_expired;
    assign live          = owner_cyc & ~expire;

    // Responses with nothing outstanding are stray and never forwarded
    assign fwd_ack = live & has_out & wb_bus.ack;
    assign fwd_err = live & has_out & wb_bus.err;
    assign stb_out = live & owner_stb & ~full;
    assign accept  = stb_out & ~wb_bus.stall;

    assign tmo_enable = owner_cyc & has_out & ~wb_bus.ack & ~wb_bus.err;
    assign tmo_clear  = ~owner_cyc | accept | wb_bus.ack | wb_bus.err;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_comb begin
        wb_bus.cyc   = live;
        wb_bus.stb   = stb_out;
        wb_bus.we    = 1'b0;
        wb_bus.addr  = '0;
        wb_bus.wdata = '0;
        wb_bus.sel   = '0;
        a_bus.stall  = 1'b1;
        a_bus.ack    = 1'b0;
        a_bus.err    = 1'b0;
        a_bus.rdata  = '0;
        b_bus.stall  = 1'b1;
        b_bus.ack    = 1'b0;
        b_bus.err    = 1'b0;
        b_bus.rdata  = '0;
        if (live && own_a) begin
            wb_bus.we    = a_bus.we;
            wb_bus.addr  = a_bus.addr;
            wb_bus.wdata = a_bus.wdata;
            wb_bus.sel   = a_bus.sel;
            a_bus.stall  = wb_bus.stall | full;
            a_bus.ack    = fwd_ack;
            a_bus.err    = fwd_err;
            a_bus.rdata  = wb_bus.rdata;
        end else if (live && own_b) begin
            wb_bus.we    = b_bus.we;
            wb_bus.addr  = b_bus.addr;
            wb_bus.wdata = b_bus.wdata;
            wb_bus.sel   = b_bus.sel;
            b_bus.stall  = wb_bus.stall | full;
            b_bus.ack    = fwd_ack;
            b_bus.err    = fwd_err;
            b_bus.rdata  = wb_bus.rdata;
        end
        if (expire) begin
            if (own_a) begin
                a_bus.err = 1'b1;
            end else begin
                b_bus.err = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        out_d    = out_q;
        unique case (state_q)
            StIdle: begin
                if (a_bus.cyc && (!b_bus.cyc || last_b_q)) begin
                    state_d  = StOwnA;
                    last_b_d = 1'b0;
                end else if (b_bus.cyc) begin
                    state_d  = StOwnB;
                    last_b_d = 1'b1;
                end
            end
            StOwnA, StOwnB: begin
                if (release_grant) begin
                    out_d = '0;
                    if (other_cyc) begin
                        state_d  = own_a ? StOwnB : StOwnA;
                        last_b_d = own_a;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (expire) begin
                    out_d   = '0;
                    state_d = StAbort;
                end else if (accept && !(fwd_ack || fwd_err)) begin
                    out_d = out_q + 1'b1;
                end else if (!accept && (fwd_ack || fwd_err)) begin
                    out_d = out_q - 1'b1;
                end
            end
            StAbort: begin
                if (!abort_cyc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            last_b_q <= 1'b1;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a cycle-level reference model checked on
// every falling edge, plus literal expectations for each scenario.
module tb_wb_arbiter;

    localparam int unsigned Tmo    = 8;
    localparam int unsigned MaxOut = 15;

    logic i_clk = 1'b0;
    logic i_reset;

    wb_arbiter_if a_if ();
    wb_arbiter_if b_if ();
    wb_arbiter_if s_if ();

    wb_arbiter #(
        .TIMEOUT_CYCLES (Tmo),
        .MAX_OUTSTANDING(MaxOut)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .a_bus  (a_if),
        .b_bus  (b_if),
        .wb_bus (s_if)
    );

    always #5 i_clk = ~i_clk;

    int tests    = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: owner 0=none 1=A 2=B, last grant 1=A 2=B
    int m_owner = 0;
    int m_last  = 2;
    int m_out   = 0;
    int m_idle  = 0;
    bit m_abort = 1'b0;

    always @(negedge i_clk) begin : model
        logic [68:0] e_wb;
        logic [34:0] e_a, e_b, e_o;
        logic        o_cyc, o_stb, o_we, oth_cyc, full, acc, rsp;
        logic [29:0] o_addr;
        logic [31:0] o_data;
        logic [3:0]  o_sel;
        int          cur;
        cur     = m_owner;
        e_wb    = '0;
        e_a     = {1'b1, 34'd0};
        e_b     = {1'b1, 34'd0};
        e_o     = {1'b1, 34'd0};
        o_cyc   = (cur == 1) ? a_if.cyc : (cur == 2) ? b_if.cyc : 1'b0;
        o_stb   = (cur == 1) ? a_if.stb : b_if.stb;
        o_we    = (cur == 1) ? a_if.we : b_if.we;
        o_addr  = (cur == 1) ? a_if.addr : b_if.addr;
        o_data  = (cur == 1) ? a_if.wdata : b_if.wdata;
        o_sel   = (cur == 1) ? a_if.sel : b_if.sel;
        oth_cyc = (cur == 1) ? b_if.cyc : a_if.cyc;
        if (i_reset) begin
            m_owner = 0; m_last = 2; m_out = 0; m_idle = 0; m_abort = 1'b0;
        end else if (m_abort) begin
            if (!o_cyc) begin
                m_owner = 0; m_abort = 1'b0;
            end
        end else if (cur == 0) begin
            if (a_if.cyc && b_if.cyc) m_owner = (m_last == 1) ? 2 : 1;
            else if (a_if.cyc) m_owner = 1;
            else if (b_if.cyc) m_owner = 2;
            if (m_owner != 0) m_last = m_owner;
            m_out = 0; m_idle = 0;
        end else if (!o_cyc) begin
            m_out = 0; m_idle = 0;
            if (oth_cyc) begin
                m_owner = 3 - cur; m_last = m_owner;
            end else begin
                m_owner = 0;
            end
        end else if (m_out > 0 && !s_if.ack && !s_if.err && m_idle + 1 == Tmo) begin
            e_o = {1'b1, 1'b0, 1'b1, 32'd0};
            m_abort = 1'b1; m_out = 0; m_idle = 0;
        end else begin
            full = (m_out == MaxOut);
            e_wb = {1'b1, o_stb && !full, o_we, o_addr, o_data, o_sel};
            e_o  = {s_if.stall || full, s_if.ack && m_out > 0, s_if.err && m_out > 0, s_if.rdata};
            acc  = o_stb && !full && !s_if.stall;
            rsp  = (s_if.ack || s_if.err) && m_out > 0;
            if (acc || rsp) m_idle = 0;
            else if (m_out > 0) m_idle = m_idle + 1;
            m_out = m_out + int'(acc) - int'(rsp);
        end
        if (cur == 1) e_a = e_o;
        else if (cur == 2) e_b = e_o;
        check("model_wb_bus", 128'({s_if.cyc, s_if.stb, s_if.we, s_if.addr, s_if.wdata, s_if.sel}),
              128'(e_wb));
        check("model_a_resp", 128'({a_if.stall, a_if.ack, a_if.err, a_if.rdata}), 128'(e_a));
        check("model_b_resp", 128'({b_if.stall, b_if.ack, b_if.err, b_if.rdata}), 128'(e_b));
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        a_if.cyc = 1'b0; a_if.stb = 1'b0; a_if.we = 1'b0;
        a_if.addr = '0; a_if.wdata = '0; a_if.sel = '0;
        b_if.cyc = 1'b0; b_if.stb = 1'b0; b_if.we = 1'b0;
        b_if.addr = '0; b_if.wdata = '0; b_if.sel = '0;
        s_if.stall = 1'b0; s_if.ack = 1'b0; s_if.err = 1'b0; s_if.rdata = '0;
    endtask

    initial begin
        i_reset = 1'b1;
        clear_inputs();
        sample();
        check("rst_a_stall", 128'(a_if.stall), 128'h1);
        check("rst_wb_cyc", 128'(s_if.cyc), 128'h0);
        tick();
        i_reset = 1'b0;
        sample();

        // Single write from A
        tick();
        a_if.cyc = 1'b1; a_if.stb = 1'b1; a_if.we = 1'b1;
        a_if.addr = 30'h10; a_if.wdata = 32'hDEADBEEF; a_if.sel = 4'hF;
        sample();
        check("s1_arb_wb_cyc", 128'(s_if.cyc), 128'h0);
        tick();
        sample();
        check("s1_wb_stb", 128'(s_if.stb), 128'h1);
        check("s1_wb_addr", 128'(s_if.addr), 128'h10);
        check("s1_wb_data", 128'(s_if.wdata), 128'hDEADBEEF);
        tick();
        a_if.stb = 1'b0; s_if.ack = 1'b1; s_if.rdata = 32'h12345678;
        sample();
        check("s1_a_ack", 128'(a_if.ack), 128'h1);
        check("s1_b_ack", 128'(b_if.ack), 128'h0);
        check("s1_a_rdata", 128'(a_if.rdata), 128'h12345678);
        tick();
        clear_inputs();
        sample();
        check("s1_rel_wb_cyc", 128'(s_if.cyc), 128'h0);

        // Simultaneous requests, twice, starting from reset
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0; a_if.cyc = 1'b1; b_if.cyc = 1'b1;
        sample();
        for (int r = 0; r < 2; r++) begin
            tick();
            sample();
            check("s2_a_granted", 128'(a_if.stall), 128'h0);
            check("s2_b_waits", 128'(b_if.stall), 128'h1);
            tick();
            a_if.cyc = 1'b0;
            sample();
            check("s2_rel_wb_cyc", 128'(s_if.cyc), 128'h0);
            tick();
            sample();
            check("s2_b_granted", 128'(b_if.stall), 128'h0);
            tick();
            b_if.cyc = 1'b0;
            sample();
            tick();
            a_if.cyc = 1'b1; b_if.cyc = 1'b1;
            sample();
        end
        tick();
        clear_inputs();
        sample();
        tick();
        sample();

        // 16 pipelined strobes with ack held off; last grant was A so A alone now
        tick();
        a_if.cyc = 1'b1; a_if.stb = 1'b1;
        sample();
        for (int n = 0; n < 15; n++) begin
            tick();
            a_if.addr = 30'(n);
            sample();
        end
        check("s3_15th_accepted", 128'(a_if.stall), 128'h0);
        tick();
        a_if.addr = 30'd15;
        sample();
        check("s3_16th_stalled", 128'(a_if.stall), 128'h1);
        check("s3_16th_no_stb", 128'(s_if.stb), 128'h0);
        tick();
        s_if.ack = 1'b1;
        sample();
        check("s3_ack_fwd", 128'(a_if.ack), 128'h1);
        tick();
        s_if.ack = 1'b0;
        sample();
        check("s3_resume_stall", 128'(a_if.stall), 128'h0);
        check("s3_resume_stb", 128'(s_if.stb), 128'h1);
        tick();
        clear_inputs();
        sample();

        // Slave never answers: timeout abort, then B gets the bus
        tick();
        a_if.cyc = 1'b1; a_if.stb = 1'b1; a_if.addr = 30'h40;
        sample();
        tick();
        sample();
        check("s4_accept", 128'(a_if.stall), 128'h0);
        tick();
        a_if.stb = 1'b0; b_if.cyc = 1'b1;
        sample();
        for (int k = 3; k <= 8; k++) begin
            tick();
            sample();
        end
        check("s4_no_err_early", 128'(a_if.err), 128'h0);
        check("s4_cyc_before", 128'(s_if.cyc), 128'h1);
        tick();
        sample();
        check("s4_err", 128'(a_if.err), 128'h1);
        check("s4_cyc_dropped", 128'(s_if.cyc), 128'h0);
        tick();
        sample();
        check("s4_err_pulse", 128'(a_if.err), 128'h0);
        check("s4_abort_stall", 128'(a_if.stall), 128'h1);
        tick();
        a_if.cyc = 1'b0;
        sample();
        tick();
        sample();
        tick();
        sample();
        check("s4_b_granted", 128'(b_if.stall), 128'h0);
        tick();
        clear_inputs();
        sample();

        // Reset with three requests outstanding
        tick();
        a_if.cyc = 1'b1; a_if.stb = 1'b1;
        sample();
        for (int k = 0; k < 3; k++) begin
            tick();
            sample();
        end
        tick();
        a_if.stb = 1'b0; i_reset = 1'b1;
        sample();
        check("s5_rst_wb_cyc", 128'(s_if.cyc), 128'h0);
        tick();
        i_reset = 1'b0; s_if.ack = 1'b1;
        sample();
        check("s5_late_ack", 128'(a_if.ack), 128'h0);
        check("s5_post_wb_cyc", 128'(s_if.cyc), 128'h0);
        tick();
        sample();
        check("s5_regrant", 128'(a_if.stall), 128'h0);
        check("s5_ack_ignored", 128'(a_if.ack), 128'h0);
        tick();
        clear_inputs();
        sample();

        // A abandons two outstanding requests while B waits
        tick();
        a_if.cyc = 1'b1; a_if.stb = 1'b1;
        sample();
        tick();
        b_if.cyc = 1'b1;
        sample();
        tick();
        sample();
        tick();
        a_if.cyc = 1'b0; a_if.stb = 1'b0;
        sample();
        check("s6_rel_wb_cyc", 128'(s_if.cyc), 128'h0);
        tick();
        b_if.stb = 1'b1; b_if.addr = 30'h20; s_if.stall = 1'b1;
        sample();
        check("s6_b_granted", 128'(s_if.cyc), 128'h1);
        check("s6_slave_stall", 128'(b_if.stall), 128'h1);
        tick();
        s_if.stall = 1'b0;
        sample();
        check("s6_b_accept", 128'(b_if.stall), 128'h0);
        tick();
        b_if.stb = 1'b0; s_if.ack = 1'b1;
        sample();
        check("s6_b_ack", 128'(b_if.ack), 128'h1);
        tick();
        sample();
        check("s6_extra_ack_dropped", 128'(b_if.ack), 128'h0);
        tick();
        clear_inputs();
        sample();
        tick();
        sample();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
